// File: rtl/apb_host_bridge.sv
// Byte-host to APB3 master bridge with address decode to NUM_SLV slaves.
// Ports: pclk/prst, host byte port, busy/done/err_code, APB3 master bus.
module apb_host_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                        pclk,
  input  logic                        prst,
  input  logic [7:0]                  host_din,
  input  logic                        host_sel,
  input  logic                        host_wr,
  input  logic                        host_rd,
  input  logic                        host_we,
  input  logic                        host_re,
  output logic [7:0]                  host_dout,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  err_code,
  output logic [ADDR_W-1:0]           paddr,
  output logic [DATA_W-1:0]           pwdata,
  output logic                        pwrite,
  output logic [NUM_SLV-1:0]          psel,
  output logic                        penable,
  input  logic [NUM_SLV*DATA_W-1:0]   prdata,
  input  logic [NUM_SLV-1:0]          pready,
  input  logic [NUM_SLV-1:0]          pslverr
);

  localparam int SW = $clog2(NUM_SLV);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    MISS
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [SW-1:0]      idx_q;
  logic               wr_q;
  logic [CW-1:0]      wait_q;
  logic               done_q;
  logic [1:0]         err_q;

  logic [SW-1:0]      idx_d;
  logic               miss;
  logic               start;
  logic               sel_rdy;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic [NUM_SLV-1:0] sel_oh;
  logic               tmo;

  assign idx_d = addr_q[ADDR_W-1 -: SW];
  assign miss  = int'(idx_d) >= NUM_SLV;
  assign start = (state == IDLE) && (host_we || host_re);

  // Only the latched slave's handshake is looked at.
  always_comb begin
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    sel_oh    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(idx_q) == i) begin
        sel_rdy   = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // wait_q counts held ACCESS cycles; abort on the TIMEOUT-th one.
  assign tmo = !sel_rdy && (wait_q == CW'(TIMEOUT - 1));

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    psel      = '0;
    penable   = 1'b0;
    unique case (state)
      IDLE: begin
        if (host_we || host_re)
          state_nxt = miss ? MISS : SETUP;
      end
      SETUP: begin
        busy      = 1'b1;
        psel      = sel_oh;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        busy    = 1'b1;
        psel    = sel_oh;
        penable = 1'b1;
        if (sel_rdy || tmo)
          state_nxt = IDLE;
      end
      MISS: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 2'd0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && host_wr) begin
        if (host_sel) wdata_q <= (wdata_q << 8) | DATA_W'(host_din);
        else          addr_q  <= (addr_q << 8) | ADDR_W'(host_din);
      end
      if (host_rd)
        rdata_q <= rdata_q >> 8;
      if (start) begin
        wr_q   <= host_we;
        idx_q  <= idx_d;
        err_q  <= miss ? 2'd3 : 2'd0;
        done_q <= miss;
      end
      if (state == SETUP)
        wait_q <= '0;
      if (state == ACCESS) begin
        if (sel_rdy) begin
          done_q <= 1'b1;
          err_q  <= sel_err ? 2'd1 : 2'd0;
          // A completing read takes priority over host_rd.
          if (!wr_q && !sel_err)
            rdata_q <= sel_rdata;
        end else if (tmo) begin
          done_q <= 1'b1;
          err_q  <= 2'd2;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
      end
    end
  end

  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pwrite    = wr_q;
  assign host_dout = rdata_q[7:0];
  assign done      = done_q;
  assign err_code  = err_q;

endmodule

// File: doc/apb_host_bridge.md
Name: apb_host_bridge

Overview:
- Parametrised successor to the byte-host APB master that drives the I2C core over APB.
- Assembles address and write data from a byte-wide host port and runs one APB3 transfer per host command.
- Supports wait states (pready), slave errors (pslverr) and a bounded-wait timeout.
- Decodes the address MSBs to one of NUM_SLV psel lines, so several APB peripherals (I2C core, others) share one host port.

Parameters:
- ADDR_W, 32, paddr width; multiple of 8, >= 8.
- DATA_W, 32, pwdata/prdata width; multiple of 8, >= 8.
- NUM_SLV, 2, number of APB slaves (>= 2); SW = clog2(NUM_SLV).
- TIMEOUT, 255, max ACCESS cycles with pready low before abort (1..65535).

Ports:
- pclk  in  1  clock.
- prst  in  1  asynchronous active-high reset.
- host_din  in  8  host byte in.
- host_sel  in  1  byte target: 0 = address register, 1 = write-data register.
- host_wr  in  1  pulse: shift host_din into the selected register.
- host_rd  in  1  pulse: shift the read-data register right by 8.
- host_we  in  1  pulse: start an APB write.
- host_re  in  1  pulse: start an APB read.
- host_dout  out  8  rdata_reg[7:0].
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err_code  out  2  0 ok, 1 pslverr, 2 timeout, 3 decode miss.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  NUM_SLV  one-hot slave select.
- penable  out  1  APB enable.
- prdata  in  NUM_SLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W].
- pready  in  NUM_SLV  per-slave ready.
- pslverr  in  NUM_SLV  per-slave error.

Behaviour:
- Reset (async, prst=1): every output and internal register is 0; state = IDLE. This takes effect immediately, including mid-transfer: psel and penable drop in the same cycle.
- Byte assembly, IDLE only, on host_wr: selected register <= {reg[W-9:0], host_din}. The MSB byte is written first; excess bytes shift out and are lost. host_wr while busy is ignored.
- Read-data register, in any state: on host_rd, rdata_reg <= rdata_reg >> 8 (zero fill). A completing read in the same cycle wins over host_rd.
- Start, IDLE only:
  - host_we -> write; host_re -> read; both high -> write, host_re dropped.
  - Starts while busy are ignored.
  - paddr, pwdata and pwrite are driven from the latched registers and held stable for the whole transfer.
- Decode: idx = addr[ADDR_W-1 -: SW]. If idx >= NUM_SLV there is no bus activity: the next cycle gives done=1 and err_code=3, busy stays high for that one cycle only.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - Start seen in cycle T. From T+1: SETUP, busy=1, psel[idx]=1, penable=0.
  - T+2: ACCESS, penable=1.
  - ACCESS holds while pready[idx]=0. A wait counter starts at 0 and increments each held cycle.
  - Completion in the cycle pready[idx]=1 is sampled. The next cycle is IDLE with psel=0, penable=0, busy=0, done=1 (one cycle).
  - err_code = pslverr[idx] ? 1 : 0.
  - A read with pslverr=0 loads rdata_reg from the prdata slice. A read with pslverr=1 leaves rdata_reg unchanged.
- Timeout: if the wait counter reaches TIMEOUT while pready[idx]=0, abort. Next cycle is IDLE, psel/penable drop, done=1, err_code=2, rdata_reg unchanged. A late pready is ignored.
- Zero-wait-state latency: start to done = 3 cycles.
- err_code holds until the next accepted start, which clears it to 0.
- Only psel[idx] is ever asserted; psel is all-zero outside SETUP/ACCESS. pready/pslverr of unselected slaves are ignored.
- The counter width covers TIMEOUT; there is no wrap before abort.

Test Plan:
- Defaults: host_wr bytes 00,00,00,10 (sel=0), then DE,AD,BE,EF (sel=1), host_we; slave0 pready=1 -> T+1 psel=01 penable=0; T+2 penable=1, paddr=0x10, pwdata=0xDEADBEEF, pwrite=1; T+3 done=1, err_code=0, busy=0.
- Read from addr 0x80000004 with slave1 pready low for 3 ACCESS cycles, prdata1=0x12345678 -> psel=10, done 6 cycles after the start, host_dout=78; after 3 host_rd pulses host_dout = 56, 34, 12.
- TIMEOUT=4, slave0 pready stuck low -> abort after 4 wait cycles; done=1, err_code=2, rdata_reg unchanged; a later pready pulse is ignored.
- Slave pslverr=1 on read; NUM_SLV=3 with idx=3 -> err_code=1 with rdata unchanged; err_code=3 with no psel, done one cycle after the start.
- host_we and host_re in the same cycle, plus host_we/host_wr during busy -> a single write is performed and registers are unchanged; prst pulsed during ACCESS -> psel/penable/busy go to 0 asynchronously, and a fresh transfer afterwards succeeds.
